// File: rtl/dm_pkg.sv
// Shared size codes and byte-lane helper for the sized data memory.
package dm_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } size_e;

    // Byte enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_B:  lane_mask = 4'b0001 << off;
            SIZE_H:  lane_mask = off[1] ? 4'b1100 : 4'b0011;
            SIZE_W:  lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dm_load_align.sv
// Extracts the addressed byte/half/word from a memory word and sign- or zero-extends it.
module dm_load_align
    import dm_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_off, 3'b000} +: 8];
    assign w_half = i_word[{i_off[1], 4'b0000} +: 16];

    always_comb begin
        o_data = '0;
        case (i_size)
            SIZE_B:  o_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            SIZE_H:  o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
            SIZE_W:  o_data = i_word;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressed data memory with sized loads/stores, error checking and a
// READ_LATENCY-stage response pipe; one in-order response per accepted request.
module data_memory_sized
    import dm_pkg::*;
#(
    parameter int          DEPTH_WORDS  = 256,
    parameter int          READ_LATENCY = 1,
    parameter int          PRESET_ADDR0 = 15,
    parameter logic [31:0] PRESET_VAL0  = 32'd65,
    parameter int          PRESET_ADDR1 = 17,
    parameter logic [31:0] PRESET_VAL1  = 32'd56,
    parameter int          ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_error
);

    localparam int BYTE_AW = $clog2(DEPTH_WORDS * 4);
    localparam int IDX_W   = BYTE_AW - 2;

    // Handshake: a request is accepted in any cycle where req_valid and req_ready
    // are both 1; responses cannot be stalled and appear READ_LATENCY cycles later.
    logic        r_ready;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic [READ_LATENCY-1:0] r_pv;
    logic [READ_LATENCY-1:0] r_pe;
    logic [31:0]             r_pd [READ_LATENCY];

    logic             w_accept;
    logic [IDX_W-1:0] w_idx;
    logic             w_oor;
    logic             w_misal;
    logic             w_err;
    logic [3:0]       w_mask;
    logic [31:0]      w_wdata_sh;
    logic [31:0]      w_word;
    logic [31:0]      w_load;

    assign w_accept   = req_valid & r_ready;
    assign w_idx      = req_addr[BYTE_AW-1:2];
    assign w_oor      = (req_addr >> BYTE_AW) != '0;
    assign w_misal    = ((req_size == SIZE_H) && req_addr[0]) ||
                        ((req_size == SIZE_W) && (req_addr[1:0] != 2'b00));
    assign w_err      = w_misal || (req_size == SIZE_X) || w_oor;
    assign w_mask     = lane_mask(req_size, req_addr[1:0]);
    assign w_wdata_sh = req_wdata << {req_addr[1:0], 3'b000};
    assign w_word     = r_mem[w_idx];

    dm_load_align u_align (
        .i_word     (w_word),
        .i_off      (req_addr[1:0]),
        .i_size     (req_size),
        .i_unsigned (req_unsigned),
        .o_data     (w_load)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= (i == PRESET_ADDR0) ? PRESET_VAL0 :
                            (i == PRESET_ADDR1) ? PRESET_VAL1 : 32'd0;
            end
        end else if (w_accept && req_write && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_mask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    // Stage 0 captures the already-extended load result; later stages only delay it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pv <= '0;
            r_pe <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                r_pd[s] <= '0;
            end
        end else begin
            r_pv[0] <= w_accept;
            r_pe[0] <= w_accept && w_err;
            r_pd[0] <= (w_accept && !req_write && !w_err) ? w_load : 32'd0;
            for (int s = 1; s < READ_LATENCY; s++) begin
                r_pv[s] <= r_pv[s-1];
                r_pe[s] <= r_pe[s-1];
                r_pd[s] <= r_pd[s-1];
            end
        end
    end

    assign req_ready = r_ready;
    assign rsp_valid = r_pv[READ_LATENCY-1];
    assign rsp_error = r_pe[READ_LATENCY-1];
    assign rsp_rdata = r_pd[READ_LATENCY-1];

endmodule

// File: tb/tb_data_memory_sized.sv
// Self-checking bench: byte-array reference model, cycle-stamped expected queue, per-cycle compare.
module tb_data_memory_sized;

    localparam int DEPTH = 256;
    localparam int LAT   = 3;
    localparam int NB    = DEPTH * 4;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    data_memory_sized #(
        .DEPTH_WORDS  (DEPTH),
        .READ_LATENCY (LAT),
        .PRESET_ADDR0 (15),
        .PRESET_VAL0  (32'd65),
        .PRESET_ADDR1 (17),
        .PRESET_VAL1  (32'd56),
        .ADDR_W       (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error)
    );

    // clock / cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // {due_cycle[31:0], error, rdata[31:0]}
    logic [64:0] exp_q[$];
    logic [7:0]  mem_b [NB];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) mem_b[i] = 8'h00;
        mem_b[60] = 8'd65;
        mem_b[68] = 8'd56;
    endtask

    // Reference behaviour on a little-endian byte array.
    task automatic model_access(input logic w, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] ed, output logic ee);
        int n;
        logic [63:0] v;
        n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        ee = (sz == 2'd3) || ((a % n) != 0) || (a >= NB);
        ed = 32'd0;
        if (!ee) begin
            if (w) begin
                for (int i = 0; i < n; i++) mem_b[a + i] = wd[8*i +: 8];
            end else begin
                v = 64'd0;
                for (int i = 0; i < n; i++) v = v | (64'(mem_b[a + i]) << (8 * i));
                if (!u && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
                ed = v[31:0];
            end
        end
    endtask

    // driver: called #1 after a rising edge, returns #1 after the next one
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] ed, output logic ee);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = wd;
        ed = 32'd0;
        ee = 1'b0;
        if (req_ready === 1'b1) begin
            model_access(w, sz, u, a, wd, ed, ee);
            exp_q.push_back({32'(cyc + LAT), ee, ed});
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic lit(input string name, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_e);
        logic [31:0] ed;
        logic        ee;
        do_req(w, sz, u, a, wd, ed, ee);
        chk({name, "_data"}, ed, exp_d);
        chk({name, "_err"}, {31'd0, ee}, {31'd0, exp_e});
    endtask

    // compare process
    always @(negedge clk) begin
        logic [64:0] e;
        if (!rst) begin
            chk("rst_ready", {31'd0, req_ready}, 32'd0);
            chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
            chk("rst_rdata", rsp_rdata, 32'd0);
            chk("rst_error", {31'd0, rsp_error}, 32'd0);
        end else if (exp_q.size() > 0 && exp_q[0][64:33] == 32'(cyc)) begin
            e = exp_q.pop_front();
            chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("rsp_rdata", rsp_rdata, e[31:0]);
            chk("rsp_error", {31'd0, rsp_error}, {31'd0, e[32]});
        end else begin
            chk("rsp_idle", {31'd0, rsp_valid}, 32'd0);
        end
    end

    initial begin
        logic [31:0] ed;
        logic        ee;
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;

        rst = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size = 2'd0;
        req_unsigned = 1'b0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        idle(1);
        chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

        // presets and an untouched word
        lit("t1_w60", 1'b0, 2'd2, 1'b0, 32'd60, 32'd0, 32'd65, 1'b0);
        lit("t1_w68", 1'b0, 2'd2, 1'b0, 32'd68, 32'd0, 32'd56, 1'b0);
        lit("t1_w80", 1'b0, 2'd2, 1'b0, 32'd80, 32'd0, 32'd0, 1'b0);
        lit("t1_top", 1'b0, 2'd2, 1'b0, 32'(NB - 4), 32'd0, 32'd0, 1'b0);

        // sized loads and extension
        lit("t2_st", 1'b1, 2'd2, 1'b0, 32'd40, 32'h8899AABB, 32'd0, 1'b0);
        lit("t2_lbs", 1'b0, 2'd0, 1'b0, 32'd41, 32'd0, 32'hFFFFFFAA, 1'b0);
        lit("t2_lbu", 1'b0, 2'd0, 1'b1, 32'd41, 32'd0, 32'h000000AA, 1'b0);
        lit("t2_lhs", 1'b0, 2'd1, 1'b0, 32'd42, 32'd0, 32'hFFFF8899, 1'b0);

        // byte store merge
        lit("t3_sb", 1'b1, 2'd0, 1'b0, 32'd43, 32'h00000011, 32'd0, 1'b0);
        lit("t3_lw", 1'b0, 2'd2, 1'b0, 32'd40, 32'd0, 32'h1199AABB, 1'b0);

        // errors
        lit("t4_mis_h", 1'b0, 2'd1, 1'b0, 32'd41, 32'd0, 32'd0, 1'b1);
        lit("t4_mis_w", 1'b0, 2'd2, 1'b0, 32'd42, 32'd0, 32'd0, 1'b1);
        lit("t4_sz11", 1'b0, 2'd3, 1'b0, 32'd40, 32'd0, 32'd0, 1'b1);
        lit("t4_oor_st", 1'b1, 2'd2, 1'b0, 32'(NB), 32'hDEADBEEF, 32'd0, 1'b1);
        lit("t4_mis_st", 1'b1, 2'd2, 1'b0, 32'd41, 32'hDEADBEEF, 32'd0, 1'b1);
        lit("t4_lw", 1'b0, 2'd2, 1'b0, 32'd40, 32'd0, 32'h1199AABB, 1'b0);
        lit("t4_oor_ld", 1'b0, 2'd0, 1'b0, 32'h8000_0028, 32'd0, 32'd0, 1'b1);
        idle(2);

        // store then dependent load back to back
        lit("t5_st", 1'b1, 2'd2, 1'b0, 32'd8, 32'd5, 32'd0, 1'b0);
        lit("t5_ld", 1'b0, 2'd2, 1'b0, 32'd8, 32'd0, 32'd5, 1'b0);
        idle(LAT + 1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                r = $urandom_range(0, 9);
                if (r == 0)      a = $urandom;
                else if (r == 1) a = 32'(NB - 4 + $urandom_range(0, 7));
                else             a = $urandom_range(0, 127);
                sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                if ($urandom_range(0, 3) != 0) begin
                    if (sz == 2'd1) a[0] = 1'b0;
                    if (sz == 2'd2) a[1:0] = 2'b00;
                end
                do_req($urandom_range(0, 9) < 4, sz, 1'($urandom_range(0, 1)), a, $urandom, ed, ee);
            end
        end
        idle(LAT + 1);

        // reset with requests in flight
        lit("t6_pre0", 1'b1, 2'd2, 1'b0, 32'd40, 32'h12345678, 32'd0, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'd60, 32'd0, ed, ee);
        do_req(1'b0, 2'd2, 1'b0, 32'd40, 32'd0, ed, ee);
        rst = 1'b0;
        exp_q.delete();
        model_reset();
        idle(2);
        rst = 1'b1;
        idle(LAT + 2);
        lit("t6_w60", 1'b0, 2'd2, 1'b0, 32'd60, 32'd0, 32'd65, 1'b0);
        lit("t6_w40", 1'b0, 2'd2, 1'b0, 32'd40, 32'd0, 32'd0, 1'b0);
        idle(LAT + 2);

        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
